// File: rtl/bus_watchdog_pkg.sv
// Shared types and constants for the multi-channel bus watchdog:
// channel FSM state encoding, CSR byte offsets and the channel-count bound.
package bus_watchdog_pkg;

    // Upper bound on monitored channels; LAST_CH is sized to index all of them.
    localparam int MAX_CH   = 32;
    localparam int CH_IDX_W = $clog2(MAX_CH);

    // CSR byte offsets.
    localparam int unsigned CSR_CH_EN     = 32'h00;
    localparam int unsigned CSR_TIMEOUT   = 32'h04;
    localparam int unsigned CSR_STATUS    = 32'h08;
    localparam int unsigned CSR_IRQ_EN    = 32'h0C;
    localparam int unsigned CSR_LAST_ADDR = 32'h10;
    localparam int unsigned CSR_LAST_CH   = 32'h14;

    // Per-channel transaction tracking state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2,
        TMO      = 2'd3
    } wdt_state_e;

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: tracks a single outstanding req/gnt/rsp transaction,
// times out the grant and response phases, and latches the request address.
// 'fire' is high in the cycle whose closing edge moves the channel into TMO.
module wdt_channel
    import bus_watchdog_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 req,
    input  logic                 gnt,
    input  logic                 rsp,
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic [CNT_W-1:0]     timeout,
    input  logic                 hold,      // STATUS bit stays set across this edge
    output logic                 fire,
    output logic [BUS_WIDTH-1:0] req_addr
);

    wdt_state_e           state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d, cnt_inc;
    logic [BUS_WIDTH-1:0] req_addr_d;
    logic                 expired;

    // A zero TIMEOUT never matches, and a counter above TIMEOUT never matches again.
    assign expired = (timeout != '0) && (cnt == timeout);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Next-state, counter and address-latch logic.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        req_addr_d = req_addr;
        fire       = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state_d    = gnt ? WAIT_RSP : WAIT_GNT;
                        cnt_d      = CNT_W'(1);
                        req_addr_d = addr;
                    end
                end
                WAIT_GNT: begin
                    if (gnt) begin
                        state_d = WAIT_RSP;
                        cnt_d   = CNT_W'(1);
                    end else if (expired) begin
                        state_d = TMO;
                        fire    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WAIT_RSP: begin
                    if (rsp) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (expired) begin
                        state_d = TMO;
                        fire    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                TMO: begin
                    // Bus inputs are ignored until software clears STATUS.
                    if (!hold) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and latched-address registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            req_addr <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            req_addr <= req_addr_d;
        end
    end

endmodule

// File: rtl/bus_watchdog_mc.sv
// Multi-channel CSR-programmable bus watchdog top level: CSR block, timeout
// capture priority, level interrupt and optional per-channel abort pulse.
// Optional feature macro: BUS_WATCHDOG_ABORT_EN (abort_o tied to 0 when undefined).
module bus_watchdog_mc
    import bus_watchdog_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_WIDTH   = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_RST = 1000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [ADDR_WIDTH-1:0]       csr_addr_i,
    input  logic [DATA_WIDTH-1:0]       csr_wdata_i,
    input  logic                        csr_write_en_i,
    output logic [DATA_WIDTH-1:0]       csr_rdata_o,
    input  logic [NUM_CH*BUS_WIDTH-1:0] bus_addr_i,
    input  logic [NUM_CH-1:0]           bus_req_i,
    input  logic [NUM_CH-1:0]           bus_gnt_i,
    input  logic [NUM_CH-1:0]           bus_rsp_i,
    output logic [NUM_CH-1:0]           abort_o,
    output logic                        watchdog_irq_o
);

    logic [NUM_CH-1:0]    ch_en, status, irq_en;
    logic [CNT_W-1:0]     timeout;
    logic [BUS_WIDTH-1:0] last_addr;
    logic [CH_IDX_W-1:0]  last_ch;

    logic [NUM_CH-1:0]    fire, hold, status_clr;
    logic [BUS_WIDTH-1:0] req_addr [NUM_CH];

    logic                 cap_valid;
    logic [CH_IDX_W-1:0]  cap_idx;
    logic [BUS_WIDTH-1:0] cap_addr;

    logic wr_ch_en, wr_timeout, wr_status, wr_irq_en;
    logic unused_wdata;

    assign wr_ch_en   = csr_write_en_i && (csr_addr_i == ADDR_WIDTH'(CSR_CH_EN));
    assign wr_timeout = csr_write_en_i && (csr_addr_i == ADDR_WIDTH'(CSR_TIMEOUT));
    assign wr_status  = csr_write_en_i && (csr_addr_i == ADDR_WIDTH'(CSR_STATUS));
    assign wr_irq_en  = csr_write_en_i && (csr_addr_i == ADDR_WIDTH'(CSR_IRQ_EN));

    // Write-one-to-clear request; a coincident new timeout still sets the bit.
    assign status_clr = wr_status ? csr_wdata_i[NUM_CH-1:0] : '0;
    assign hold       = status & ~status_clr;

    // Upper write-data bits beyond the widest register are don't-care.
    assign unused_wdata = ^csr_wdata_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wdt_channel #(
            .BUS_WIDTH (BUS_WIDTH),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .en       (ch_en[c]),
            .req      (bus_req_i[c]),
            .gnt      (bus_gnt_i[c]),
            .rsp      (bus_rsp_i[c]),
            .addr     (bus_addr_i[c*BUS_WIDTH +: BUS_WIDTH]),
            .timeout  (timeout),
            .hold     (hold[c]),
            .fire     (fire[c]),
            .req_addr (req_addr[c])
        );
    end

    // Pick the lowest-index channel among those timing out this cycle.
    always_comb begin
        cap_valid = 1'b0;
        cap_idx   = '0;
        cap_addr  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (fire[c]) begin
                cap_valid = 1'b1;
                cap_idx   = CH_IDX_W'(c);
                cap_addr  = req_addr[c];
            end
        end
    end

    // CSR registers, sticky status and timeout capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_en     <= '1;
            timeout   <= CNT_W'(TIMEOUT_RST);
            status    <= '0;
            irq_en    <= '0;
            last_addr <= '0;
            last_ch   <= '0;
        end else begin
            if (wr_ch_en)   ch_en   <= csr_wdata_i[NUM_CH-1:0];
            if (wr_timeout) timeout <= csr_wdata_i[CNT_W-1:0];
            if (wr_irq_en)  irq_en  <= csr_wdata_i[NUM_CH-1:0];
            status <= hold | fire;
            if (cap_valid) begin
                last_addr <= cap_addr;
                last_ch   <= cap_idx;
            end
        end
    end

    // Combinational CSR read mux; unused upper bits and unmapped offsets read 0.
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_WIDTH'(CSR_CH_EN):     csr_rdata_o[NUM_CH-1:0]    = ch_en;
            ADDR_WIDTH'(CSR_TIMEOUT):   csr_rdata_o[CNT_W-1:0]     = timeout;
            ADDR_WIDTH'(CSR_STATUS):    csr_rdata_o[NUM_CH-1:0]    = status;
            ADDR_WIDTH'(CSR_IRQ_EN):    csr_rdata_o[NUM_CH-1:0]    = irq_en;
            ADDR_WIDTH'(CSR_LAST_ADDR): csr_rdata_o[BUS_WIDTH-1:0] = last_addr;
            ADDR_WIDTH'(CSR_LAST_CH):   csr_rdata_o[CH_IDX_W-1:0]  = last_ch;
            default:                    csr_rdata_o                = '0;
        endcase
    end

    // Interrupt is a pure function of registers, never of bus inputs.
    assign watchdog_irq_o = |(status & irq_en);

`ifdef BUS_WATCHDOG_ABORT_EN
    logic [NUM_CH-1:0] abort_q;

    // One-cycle abort pulse during the first cycle a channel spends in TMO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) abort_q <= '0;
        else         abort_q <= fire;
    end

    assign abort_o = abort_q;
`else
    assign abort_o = '0;
`endif

endmodule

// File: tb/tb_bus_watchdog_mc.sv
// Self-checking bench for bus_watchdog_mc: CSR vector table plus hand-written
// multi-cycle sequences, with expected values queued in a scoreboard.
module tb_bus_watchdog_mc;

    localparam int NUM_CH = 4;
    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int BW     = 32;

`ifdef BUS_WATCHDOG_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    localparam logic [AW-1:0] A_CH_EN   = 12'h000;
    localparam logic [AW-1:0] A_TIMEOUT = 12'h004;
    localparam logic [AW-1:0] A_STATUS  = 12'h008;
    localparam logic [AW-1:0] A_IRQ_EN  = 12'h00C;
    localparam logic [AW-1:0] A_LADDR   = 12'h010;
    localparam logic [AW-1:0] A_LCH     = 12'h014;

    logic                   clk;
    logic                   rst_n;
    logic [AW-1:0]          csr_addr;
    logic [DW-1:0]          csr_wdata;
    logic                   csr_we;
    logic [DW-1:0]          csr_rdata;
    logic [NUM_CH*BW-1:0]   bus_addr;
    logic [NUM_CH-1:0]      bus_req, bus_gnt, bus_rsp;
    logic [NUM_CH-1:0]      abort;
    logic                   irq;

    bus_watchdog_mc #(
        .NUM_CH      (NUM_CH),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BUS_WIDTH   (BW),
        .CNT_W       (16),
        .TIMEOUT_RST (1000)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .csr_addr_i     (csr_addr),
        .csr_wdata_i    (csr_wdata),
        .csr_write_en_i (csr_we),
        .csr_rdata_o    (csr_rdata),
        .bus_addr_i     (bus_addr),
        .bus_req_i      (bus_req),
        .bus_gnt_i      (bus_gnt),
        .bus_rsp_i      (bus_rsp),
        .abort_o        (abort),
        .watchdog_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        bit            do_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        string         name;
        logic [DW-1:0] exp;
    } sb_t;

    vec_t rst_vecs[8];
    vec_t rw_vecs[11];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [DW-1:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [DW-1:0] act);
        sb_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got 0x%08h, expected no output", act);
        end else begin
            e = sb.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_we    = 1'b1;
        @(posedge clk);
        #1;
        csr_we    = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        push(name, exp);
        rd(a, d);
        observe(d);
    endtask

    task automatic apply_vecs(input vec_t v[], input int n);
        for (int i = 0; i < n; i++) begin
            if (v[i].do_wr) wr(v[i].addr, v[i].wdata);
            expect_reg(v[i].name, v[i].addr, v[i].exp);
        end
    endtask

    task automatic set_addr(input int ch, input logic [BW-1:0] a);
        bus_addr[ch*BW +: BW] = a;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL sim_timeout: run did not complete, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [NUM_CH-1:0] ab_seen;

        rst_vecs[0] = '{"rst_ch_en",    1'b0, A_CH_EN,   32'h0, 32'h0000_000F};
        rst_vecs[1] = '{"rst_timeout",  1'b0, A_TIMEOUT, 32'h0, 32'd1000};
        rst_vecs[2] = '{"rst_status",   1'b0, A_STATUS,  32'h0, 32'h0};
        rst_vecs[3] = '{"rst_irq_en",   1'b0, A_IRQ_EN,  32'h0, 32'h0};
        rst_vecs[4] = '{"rst_last_addr",1'b0, A_LADDR,   32'h0, 32'h0};
        rst_vecs[5] = '{"rst_last_ch",  1'b0, A_LCH,     32'h0, 32'h0};
        rst_vecs[6] = '{"rst_unmap_18", 1'b0, 12'h018,   32'h0, 32'h0};
        rst_vecs[7] = '{"rst_unmap_ffc",1'b0, 12'hFFC,   32'h0, 32'h0};

        rw_vecs[0]  = '{"rw_ch_en_all",  1'b1, A_CH_EN,   32'hFFFF_FFFF, 32'h0000_000F};
        rw_vecs[1]  = '{"rw_ch_en_5",    1'b1, A_CH_EN,   32'h0000_0005, 32'h0000_0005};
        rw_vecs[2]  = '{"rw_ch_en_f",    1'b1, A_CH_EN,   32'h0000_000F, 32'h0000_000F};
        rw_vecs[3]  = '{"rw_timeout_hi", 1'b1, A_TIMEOUT, 32'hABCD_1234, 32'h0000_1234};
        rw_vecs[4]  = '{"rw_timeout_rs", 1'b1, A_TIMEOUT, 32'h0000_03E8, 32'h0000_03E8};
        rw_vecs[5]  = '{"rw_irq_en_a",   1'b1, A_IRQ_EN,  32'hFFFF_FFFA, 32'h0000_000A};
        rw_vecs[6]  = '{"rw_irq_en_0",   1'b1, A_IRQ_EN,  32'h0000_0000, 32'h0};
        rw_vecs[7]  = '{"rw_status_w1c0",1'b1, A_STATUS,  32'h0000_000F, 32'h0};
        rw_vecs[8]  = '{"rw_last_addr_ro",1'b1,A_LADDR,   32'hDEAD_BEEF, 32'h0};
        rw_vecs[9]  = '{"rw_last_ch_ro", 1'b1, A_LCH,     32'h0000_001F, 32'h0};
        rw_vecs[10] = '{"rw_unmap_wr",   1'b1, 12'h018,   32'hFFFF_FFFF, 32'h0};

        rst_n     = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;
        csr_we    = 1'b0;
        bus_addr  = '0;
        bus_req   = '0;
        bus_gnt   = '0;
        bus_rsp   = '0;

        // Reset state.
        #1;
        push("rst_irq", 0);            observe(irq);
        push("rst_abort", 0);          observe(abort);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        apply_vecs(rst_vecs, 8);
        apply_vecs(rw_vecs, 11);

        // Grant-phase timeout on ch0 with TIMEOUT=4.
        wr(A_TIMEOUT, 32'd4);
        wr(A_IRQ_EN, 32'h1);
        set_addr(0, 32'hA000_0010);
        bus_req[0] = 1'b1;
        @(posedge clk);                                   // E0
        repeat (3) begin
            @(posedge clk); #1;                           // E1..E3
            push("t1_irq_early", 0);   observe(irq);
        end
        @(posedge clk); #1;                               // E4
        push("t1_irq", 1);             observe(irq);
        push("t1_abort", ABORT_ON ? 32'h1 : 32'h0); observe(abort);
        @(posedge clk); #1;
        push("t1_abort_end", 0);       observe(abort);
        bus_req[0] = 1'b0;
        expect_reg("t1_status", A_STATUS, 32'h1);
        expect_reg("t1_last_addr", A_LADDR, 32'hA000_0010);
        expect_reg("t1_last_ch", A_LCH, 32'h0);
        wr(A_STATUS, 32'h1);
        push("t1_irq_clr", 0);         observe(irq);
        expect_reg("t1_status_clr", A_STATUS, 32'h0);

        // ch1 granted in the 2nd cycle, response 3 cycles later: no timeout.
        set_addr(1, 32'h0000_1110);
        bus_req[1] = 1'b1;
        @(posedge clk); #1;                               // E0
        bus_gnt[1] = 1'b1;
        @(posedge clk); #1;                               // E1: grant
        bus_gnt[1] = 1'b0;
        bus_req[1] = 1'b0;
        repeat (2) @(posedge clk);                        // E2, E3
        #1 bus_rsp[1] = 1'b1;
        @(posedge clk); #1;                               // E4: response
        bus_rsp[1] = 1'b0;
        repeat (8) @(posedge clk);
        expect_reg("t2_status", A_STATUS, 32'h0);
        push("t2_irq", 0);             observe(irq);

        // ch2 and ch3 time out on the same edge.
        wr(A_IRQ_EN, 32'hF);
        set_addr(2, 32'h2222_0000);
        set_addr(3, 32'h3333_0000);
        bus_req[3:2] = 2'b11;
        @(posedge clk);                                   // E0
        repeat (3) @(posedge clk);
        @(posedge clk); #1;                               // E4
        push("t3_abort", ABORT_ON ? 32'hC : 32'h0); observe(abort);
        push("t3_irq", 1);             observe(irq);
        bus_req[3:2] = 2'b00;
        expect_reg("t3_status", A_STATUS, 32'hC);
        expect_reg("t3_last_ch", A_LCH, 32'h2);
        expect_reg("t3_last_addr", A_LADDR, 32'h2222_0000);
        wr(A_STATUS, 32'h4);
        expect_reg("t3_status_w1c4", A_STATUS, 32'h8);
        push("t3_irq_hold", 1);        observe(irq);
        wr(A_STATUS, 32'h8);
        push("t3_irq_drop", 0);        observe(irq);

        // W1C on the same edge as a new timeout of that channel: set wins.
        bus_req[0] = 1'b1;
        repeat (5) @(posedge clk);
        expect_reg("t4_first_tmo", A_STATUS, 32'h1);
        wr(A_CH_EN, 32'hE);
        wr(A_CH_EN, 32'hF);
        repeat (4) @(posedge clk);                        // E0..E3
        wr(A_STATUS, 32'h1);                              // E4
        expect_reg("t4_set_wins", A_STATUS, 32'h1);
        bus_req[0] = 1'b0;
        wr(A_STATUS, 32'h1);
        expect_reg("t4_status_clr", A_STATUS, 32'h0);

        // Disabling ch0 during the response phase abandons the transaction.
        bus_req[0] = 1'b1;
        bus_gnt[0] = 1'b1;
        @(posedge clk); #1;                               // -> WAIT_RSP
        bus_req[0] = 1'b0;
        bus_gnt[0] = 1'b0;
        @(posedge clk); #1;
        wr(A_CH_EN, 32'hE);
        ab_seen = '0;
        repeat (10) begin
            @(posedge clk); #1;
            ab_seen |= abort;
        end
        push("t5_no_abort", 0);        observe(ab_seen);
        wr(A_CH_EN, 32'hF);
        repeat (10) @(posedge clk);
        expect_reg("t5_status", A_STATUS, 32'h0);
        push("t5_irq", 0);             observe(irq);

        // TIMEOUT=0 disables timeouts; a saturated counter never fires later.
        wr(A_TIMEOUT, 32'd0);
        bus_req[1] = 1'b1;
        repeat (70000) @(posedge clk);
        expect_reg("t6_no_tmo", A_STATUS, 32'h0);
        wr(A_TIMEOUT, 32'd5);
        repeat (10) @(posedge clk);
        expect_reg("t6_saturated", A_STATUS, 32'h0);
        bus_req[1] = 1'b0;
        bus_gnt[1] = 1'b1;
        @(posedge clk); #1;
        bus_gnt[1] = 1'b0;
        bus_rsp[1] = 1'b1;
        @(posedge clk); #1;
        bus_rsp[1] = 1'b0;

        // Asynchronous reset while in TMO with irq high.
        wr(A_TIMEOUT, 32'd4);
        bus_req[3] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        push("t7_irq_pre", 1);         observe(irq);
        rst_n = 1'b0;
        #1;
        push("t7_irq_rst", 0);         observe(irq);
        push("t7_abort_rst", 0);       observe(abort);
        bus_req[3] = 1'b0;
        apply_vecs(rst_vecs, 8);
        @(negedge clk) rst_n = 1'b1;
        ab_seen = '0;
        repeat (3) begin
            @(posedge clk); #1;
            ab_seen |= abort;
        end
        push("t7_abort_release", 0);   observe(ab_seen);
        push("t7_irq_release", 0);     observe(irq);

        check("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
